// File: rtl/cnn_pkg.sv
// Shared constants and FSM state encoding for the CNN sequencer slice.
package cnn_pkg;

    localparam int unsigned IMG_W_DEF        = 227;
    localparam int unsigned IMG_H_DEF        = 227;
    localparam int unsigned BIAS_WORDS_DEF   = 64;
    localparam int unsigned WEIGHT_WORDS_DEF = 192;
    localparam int unsigned COORD_W          = $clog2(IMG_W_DEF);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StClr        = 3'd1,
        StLoadBias   = 3'd2,
        StLoadWeight = 3'd3,
        StFill       = 3'd4,
        StRun        = 3'd5,
        StDone       = 3'd6
    } state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order (row, col) pixel position counter with flags for the
// position currently being accepted.
module raster_counter
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last,
    output logic          col_ge2,
    output logic          fill_done
);

    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [CW-1:0] RowLast = CW'(IMG_H - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == ColLast) begin
                col <= '0;
                row <= (row == RowLast) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign last      = (row == RowLast) && (col == ColLast);
    assign col_ge2   = (col >= CW'(2));
    // Pixel (2,1) is the last one needed before the first 3x3 window exists.
    assign fill_done = (row == CW'(2)) && (col == CW'(1));

endmodule

// File: rtl/cnn_sequencer.sv
// Convolution datapath controller: bias load, weight load, then pixel
// streaming with window-valid tagging.
module cnn_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W        = IMG_W_DEF,
    parameter int unsigned IMG_H        = IMG_H_DEF,
    parameter int unsigned BIAS_WORDS   = BIAS_WORDS_DEF,
    parameter int unsigned WEIGHT_WORDS = WEIGHT_WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     skip_prm,
    input  logic                     prm_valid,
    output logic                     prm_ready,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic                     out_ready,
    output logic                     bias_en,
    output logic                     weight_en,
    output logic                     pixel_en,
    output logic                     bias_rst,
    output logic                     weight_rst,
    output logic                     pixel_rst,
    output logic                     win_valid,
    output logic [$clog2(IMG_W)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               state
);

    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned WCW = $clog2(WEIGHT_WORDS);
    localparam logic [WCW-1:0] BiasLast   = WCW'(BIAS_WORDS - 1);
    localparam logic [WCW-1:0] WeightLast = WCW'(WEIGHT_WORDS - 1);

    state_e         state_q;
    logic           eff_skip_q;
    logic           prm_loaded_q;
    logic [WCW-1:0] word_cnt_q;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic           last_px;
    logic           col_ge2;
    logic           fill_done;
    logic           eff_skip_d;

    assign prm_ready  = (state_q == StLoadBias) || (state_q == StLoadWeight);
    assign pix_ready  = (state_q == StFill) || ((state_q == StRun) && out_ready);
    assign bias_en    = (state_q == StLoadBias) && prm_valid;
    assign weight_en  = (state_q == StLoadWeight) && prm_valid;
    assign pixel_en   = pix_valid && pix_ready;
    assign busy       = (state_q != StIdle);
    assign state      = state_q;
    assign eff_skip_d = skip_prm && prm_loaded_q;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == StClr),
        .inc       (pixel_en),
        .row       (row),
        .col       (col),
        .last      (last_px),
        .col_ge2   (col_ge2),
        .fill_done (fill_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            eff_skip_q   <= 1'b0;
            prm_loaded_q <= 1'b0;
            word_cnt_q   <= '0;
            bias_rst     <= 1'b1;
            weight_rst   <= 1'b1;
            pixel_rst    <= 1'b1;
            win_valid    <= 1'b0;
            win_row      <= '0;
            win_col      <= '0;
            done         <= 1'b0;
        end else begin
            bias_rst   <= 1'b0;
            weight_rst <= 1'b0;
            pixel_rst  <= 1'b0;
            win_valid  <= 1'b0;
            done       <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StClr;
                        eff_skip_q <= eff_skip_d;
                        // Buffer clears are registered so they line up with the CLR cycle.
                        pixel_rst  <= 1'b1;
                        bias_rst   <= ~eff_skip_d;
                        weight_rst <= ~eff_skip_d;
                    end
                end
                StClr: begin
                    word_cnt_q <= '0;
                    state_q    <= eff_skip_q ? StFill : StLoadBias;
                end
                StLoadBias: begin
                    if (bias_en) begin
                        if (word_cnt_q == BiasLast) begin
                            word_cnt_q <= '0;
                            state_q    <= StLoadWeight;
                        end else begin
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end
                end
                StLoadWeight: begin
                    if (weight_en) begin
                        if (word_cnt_q == WeightLast) begin
                            prm_loaded_q <= 1'b1;
                            state_q      <= StFill;
                        end else begin
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end
                end
                StFill: begin
                    if (pixel_en && fill_done) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (pixel_en) begin
                        if (col_ge2) begin
                            win_valid <= 1'b1;
                            win_row   <= row - CW'(2);
                            win_col   <= col - CW'(2);
                        end
                        if (last_px) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_sequencer.sv
// Self-checking bench for cnn_sequencer on a reduced image size, with a
// raster-arithmetic reference model for pixel accepts and window tags.
module tb_cnn_sequencer;

    localparam int IW   = 9;
    localparam int IH   = 7;
    localparam int BW   = 64;
    localparam int WW   = 192;
    localparam int NPIX = IW * IH;
    localparam int NWIN = (IW - 2) * (IH - 2);
    localparam int CWT  = $clog2(IW);

    logic clk = 1'b0;
    logic rst, start, skip_prm, prm_valid, pix_valid, out_ready;
    logic prm_ready, pix_ready, bias_en, weight_en, pixel_en;
    logic bias_rst, weight_rst, pixel_rst, win_valid, busy, done;
    logic [CWT-1:0] win_row, win_col;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cnn_sequencer #(
        .IMG_W        (IW),
        .IMG_H        (IH),
        .BIAS_WORDS   (BW),
        .WEIGHT_WORDS (WW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .skip_prm   (skip_prm),
        .prm_valid  (prm_valid),
        .prm_ready  (prm_ready),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .out_ready  (out_ready),
        .bias_en    (bias_en),
        .weight_en  (weight_en),
        .pixel_en   (pixel_en),
        .bias_rst   (bias_rst),
        .weight_rst (weight_rst),
        .pixel_rst  (pixel_rst),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    typedef struct {int cyc; int r; int c;} win_t;

    bit   mon_on = 1'b0;
    int   cyc, bias_n, weight_n, bias_last, weight_last, brst_n, wrst_n, prst_n;
    int   clr_n, clr_cyc, lw_enter, fill_enter, hs_n, en_bad, pr_bad;
    int   pix_cyc[$];
    win_t win_q[$];
    int   done_cyc[$];

    // Observation only; sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_on) begin
            cyc = cyc + 1;
            if (bias_en === 1'b1) begin
                bias_n = bias_n + 1;
                if (bias_n == BW) bias_last = cyc;
            end
            if (weight_en === 1'b1) begin
                weight_n = weight_n + 1;
                if (weight_n == WW) weight_last = cyc;
            end
            if (pixel_en === 1'b1) pix_cyc.push_back(cyc);
            if (win_valid === 1'b1) win_q.push_back('{cyc, int'(win_row), int'(win_col)});
            if (done === 1'b1) done_cyc.push_back(cyc);
            if (bias_rst === 1'b1) brst_n = brst_n + 1;
            if (weight_rst === 1'b1) wrst_n = wrst_n + 1;
            if (pixel_rst === 1'b1) prst_n = prst_n + 1;
            if (state === 3'd1) begin
                clr_n = clr_n + 1;
                if (clr_cyc < 0) clr_cyc = cyc;
            end
            if (state === 3'd3 && lw_enter < 0) lw_enter = cyc;
            if (state === 3'd4 && fill_enter < 0) fill_enter = cyc;
            if (prm_valid && prm_ready === 1'b1) hs_n = hs_n + 1;
            if ((bias_en === 1'b1 || weight_en === 1'b1) && !(prm_valid && prm_ready === 1'b1))
                en_bad = en_bad + 1;
            if (state === 3'd5 && pix_ready !== out_ready) pr_bad = pr_bad + 1;
            if (state === 3'd4 && pix_ready !== 1'b1) pr_bad = pr_bad + 1;
        end
    end

    task automatic mon_clear();
        cyc = 0; bias_n = 0; weight_n = 0; bias_last = -1; weight_last = -1;
        brst_n = 0; wrst_n = 0; prst_n = 0; clr_n = 0; clr_cyc = -1;
        lw_enter = -1; fill_enter = -1; hs_n = 0; en_bad = 0; pr_bad = 0;
        pix_cyc.delete(); win_q.delete(); done_cyc.delete();
    endtask

    // Reference: accept k is pixel (k/IW, k%IW); a full 3x3 window exists when
    // both coordinates are >= 2, tagged (r-2, c-2), visible the cycle after.
    function automatic int first_bad_win();
        int j = 0;
        for (int k = 0; k < pix_cyc.size(); k++) begin
            int r;
            int c;
            r = k / IW;
            c = k % IW;
            if (r >= 2 && c >= 2) begin
                if (j >= win_q.size()) return k;
                if (win_q[j].cyc != pix_cyc[k] + 1 || win_q[j].r != r - 2 ||
                    win_q[j].c != c - 2) return k;
                j++;
            end
        end
        if (j != win_q.size()) return 100000 + j;
        return -1;
    endfunction

    // Entered and left at posedge+1.
    task automatic do_run(input bit skip, input int prm_pct, input int pix_pct,
                          input bit bp, input bit poke);
        mon_clear();
        mon_on   = 1'b1;
        start    = 1'b1;
        skip_prm = skip;
        @(posedge clk); #1;
        start    = 1'b0;
        skip_prm = 1'b0;
        for (int i = 0; i < 20000 && done_cyc.size() == 0; i++) begin
            prm_valid = ($urandom_range(99) < prm_pct);
            pix_valid = ($urandom_range(99) < pix_pct);
            out_ready = bp ? (((i / 3) % 2) == 0) : 1'b1;
            start     = poke && ((i % 7) == 3);
            @(posedge clk); #1;
        end
        start = 1'b0; prm_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b0;
        n_tests++;
        if (done_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL run_done_pulses: got %0d expected 1", done_cyc.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; skip_prm = 1'b0;
        prm_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({state, busy, done, win_valid, prm_ready, pix_ready, bias_rst, weight_rst,
             pixel_rst, win_row, win_col} !== {3'd0, 5'b00000, 3'b111, {2*CWT{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_values: got st=%0d busy=%b done=%b wv=%b rst=%b%b%b expected 0/0/0/0/111",
                     state, busy, done, win_valid, bias_rst, weight_rst, pixel_rst);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bias_rst, weight_rst, pixel_rst} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_hold_clears: got %b expected 111", {bias_rst, weight_rst, pixel_rst});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({bias_rst, weight_rst, pixel_rst, state, busy} !== {3'b000, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got rst=%b st=%0d busy=%b expected 000/0/0",
                     {bias_rst, weight_rst, pixel_rst}, state, busy);
        end
    endtask

    task automatic test_skip_after_reset();
        do_run(1'b1, 100, 100, 1'b0, 1'b0);
        n_tests++;
        if (bias_n != BW || weight_n != WW) begin
            n_fail++;
            $display("FAIL skip_after_reset_load: got %0d/%0d expected %0d/%0d",
                     bias_n, weight_n, BW, WW);
        end
        n_tests++;
        if (brst_n != 1 || wrst_n != 1) begin
            n_fail++;
            $display("FAIL skip_after_reset_clears: got %0d/%0d expected 1/1", brst_n, wrst_n);
        end
    endtask

    task automatic test_full_run();
        int got;
        do_run(1'b0, 100, 100, 1'b0, 1'b1);
        n_tests++;
        if (bias_n != BW || weight_n != WW || pix_cyc.size() != NPIX) begin
            n_fail++;
            $display("FAIL full_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     bias_n, weight_n, pix_cyc.size(), BW, WW, NPIX);
        end
        n_tests++;
        if (win_q.size() != NWIN) begin
            n_fail++;
            $display("FAIL full_win_count: got %0d expected %0d", win_q.size(), NWIN);
        end
        got = first_bad_win();
        n_tests++;
        if (got != -1) begin
            n_fail++;
            $display("FAIL full_win_seq: got first bad index %0d expected -1", got);
        end
        got = (win_q.size() > 0 && pix_cyc.size() > 2 * IW + 2) ?
              win_q[0].cyc - pix_cyc[2 * IW + 2] : -1;
        n_tests++;
        if (got != 1 || win_q.size() == 0 || win_q[0].r != 0 || win_q[0].c != 0) begin
            n_fail++;
            $display("FAIL full_first_win: got delay %0d expected 1 at (0,0)", got);
        end
        got = (done_cyc.size() > 0) ? done_cyc[0] - clr_cyc : -1;
        n_tests++;
        if (got != 1 + BW + WW + NPIX) begin
            n_fail++;
            $display("FAIL full_done_time: got %0d expected %0d", got, 1 + BW + WW + NPIX);
        end
        n_tests++;
        if (clr_n != 1) begin
            n_fail++;
            $display("FAIL start_while_busy: got %0d CLR cycles expected 1", clr_n);
        end
        n_tests++;
        if (brst_n != 1 || wrst_n != 1 || prst_n != 1) begin
            n_fail++;
            $display("FAIL full_clears: got %0d/%0d/%0d expected 1/1/1", brst_n, wrst_n, prst_n);
        end
    endtask

    task automatic test_param_reuse();
        int got;
        do_run(1'b1, 100, 100, 1'b0, 1'b0);
        n_tests++;
        if (bias_n != 0 || weight_n != 0 || brst_n != 0 || wrst_n != 0 || prst_n != 1) begin
            n_fail++;
            $display("FAIL reuse_no_load: got en %0d/%0d rst %0d/%0d/%0d expected 0/0 0/0/1",
                     bias_n, weight_n, brst_n, wrst_n, prst_n);
        end
        n_tests++;
        if (fill_enter != clr_cyc + 1) begin
            n_fail++;
            $display("FAIL reuse_fill_entry: got %0d expected %0d", fill_enter, clr_cyc + 1);
        end
        got = (done_cyc.size() > 0) ? done_cyc[0] - clr_cyc : -1;
        n_tests++;
        if (got != 1 + NPIX) begin
            n_fail++;
            $display("FAIL reuse_done_time: got %0d expected %0d", got, 1 + NPIX);
        end
    endtask

    task automatic test_param_stall();
        int got;
        do_run(1'b0, 30, 100, 1'b0, 1'b0);
        n_tests++;
        if (bias_n != BW || weight_n != WW || hs_n != BW + WW || en_bad != 0) begin
            n_fail++;
            $display("FAIL stall_handshakes: got %0d/%0d hs=%0d bad=%0d expected %0d/%0d hs=%0d bad=0",
                     bias_n, weight_n, hs_n, en_bad, BW, WW, BW + WW);
        end
        n_tests++;
        if (lw_enter != bias_last + 1 || fill_enter != weight_last + 1) begin
            n_fail++;
            $display("FAIL stall_transitions: got %0d/%0d expected %0d/%0d",
                     lw_enter, fill_enter, bias_last + 1, weight_last + 1);
        end
        got = first_bad_win();
        n_tests++;
        if (got != -1) begin
            n_fail++;
            $display("FAIL stall_win_seq: got first bad index %0d expected -1", got);
        end
    endtask

    task automatic test_back_pressure();
        int got;
        do_run(1'b1, 100, 80, 1'b1, 1'b0);
        n_tests++;
        if (pr_bad != 0) begin
            n_fail++;
            $display("FAIL bp_pix_ready: got %0d bad cycles expected 0", pr_bad);
        end
        n_tests++;
        if (win_q.size() != NWIN) begin
            n_fail++;
            $display("FAIL bp_win_count: got %0d expected %0d", win_q.size(), NWIN);
        end
        got = first_bad_win();
        n_tests++;
        if (got != -1) begin
            n_fail++;
            $display("FAIL bp_win_seq: got first bad index %0d expected -1", got);
        end
        got = (done_cyc.size() > 0 && pix_cyc.size() > 0) ? done_cyc[0] - pix_cyc[$] : -1;
        n_tests++;
        if (got != 1) begin
            n_fail++;
            $display("FAIL bp_done_after_last: got %0d expected 1", got);
        end
    endtask

    // Uses the data captured by the preceding run.
    task automatic test_row_edges();
        int hits = 0;
        for (int k = 0; k < pix_cyc.size(); k++) begin
            if ((k % IW) < 2) begin
                foreach (win_q[j]) if (win_q[j].cyc == pix_cyc[k] + 1) hits++;
            end
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL edge_no_win_col01: got %0d windows expected 0", hits);
        end
        n_tests++;
        if (win_q.size() == 0 || win_q[$].r != IH - 3 || win_q[$].c != IW - 3) begin
            n_fail++;
            $display("FAIL edge_last_win: got (%0d,%0d) expected (%0d,%0d)",
                     win_q.size() ? win_q[$].r : -1, win_q.size() ? win_q[$].c : -1,
                     IH - 3, IW - 3);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1; skip_prm = 1'b0; prm_valid = 1'b1; pix_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000 && state !== 3'd3; i++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got state %0d expected 3", state);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({state, busy, prm_ready, bias_rst, weight_rst, pixel_rst} !== {3'd0, 2'b00, 3'b111}) begin
            n_fail++;
            $display("FAIL midload_reset: got st=%0d busy=%b rdy=%b rst=%b expected 0/0/0/111",
                     state, busy, prm_ready, {bias_rst, weight_rst, pixel_rst});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2000 && state !== 3'd5; i++) begin
            @(posedge clk); #1;
        end
        repeat (IW + 4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({state, busy, pix_ready, win_valid, done, bias_rst, weight_rst, pixel_rst,
             win_row, win_col} !== {3'd0, 4'b0000, 3'b111, {2*CWT{1'b0}}}) begin
            n_fail++;
            $display("FAIL midrun_reset: got st=%0d busy=%b prdy=%b wv=%b rc=%0d,%0d expected 0",
                     state, busy, pix_ready, win_valid, win_row, win_col);
        end
        prm_valid = 1'b0; pix_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_param_reuse();
        test_param_stall();
        test_back_pressure();
        test_row_edges();
        test_mid_reset();
        test_skip_after_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
